// File: rtl/core_pkg.sv
// Shared definitions for the pipeline control blocks of the 5-stage MIPS core.
//   hz_state_t     : hazard controller state encoding
//   REG_ZERO       : architectural zero register ($0), never a real dependency
//   LU_BUBBLES_DEF : default bubbles per load-use hazard (MEM->EX forwarding present)
package core_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        HALT    = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int LU_BUBBLES_DEF = 1;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator. Flags when the instruction in ID reads a register
// that a load currently in EX has not produced yet. Purely combinational;
// also used by the forwarding unit.
// Ports:
//   id_rs, id_rt         : source register fields of the ID instruction
//   id_use_rs, id_use_rt : ID instruction actually reads rs / rt
//   ex_ld                : EX instruction is a load
//   ex_rd                : destination register of the EX instruction
//   hit                  : load-use dependency present
module hazard_cmp
    import core_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_ld,
    input  logic [4:0] ex_rd,
    output logic       hit
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_use_rs && (id_rs == ex_rd);
    assign rt_match = id_use_rt && (id_rt == ex_rd);

    // Writes to $0 are discarded, so they never create a dependency.
    assign hit = ex_ld && (ex_rd != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller.
// Produces the load enables and synchronous clears of the PC and the four
// pipeline registers, resolving (highest first): data-memory wait, syscall
// halt, taken branch/jump, load-use hazard. Keeps saturating stall/flush
// statistics for the debug display.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow; hazards detected and resolved here
// LDSTALL | extra load-use bubbles beyond the first (LU_BUBBLES > 1)
// HALT    | syscall halt; whole pipe frozen until resume
//
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   id_rs/id_rt/id_use_rs/rt   : ID source operands and their use flags
//   ex_ld, ex_rd               : EX instruction is a load, and its destination
//   ex_branch_taken            : control transfer resolved taken in EX
//   ex_halt                    : EX holds a halt syscall
//   mem_busy                   : data memory not ready, freeze everything
//   resume                     : pulse leaving HALT
//   pc_en, *_en                : register load enables
//   *_flush                    : register synchronous clears (override enable)
//   halted                     : controller in HALT
//   stall_cnt, flush_cnt       : saturating statistics
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int LU_BUBBLES = LU_BUBBLES_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_ld,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_halt,
    input  logic             mem_busy,
    input  logic             resume,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The first bubble is issued from RUN; LDSTALL counts the remainder down.
    localparam logic [1:0] BUB_INIT = 2'(LU_BUBBLES - 1);

    hz_state_t  state;
    hz_state_t  nxt_state;
    logic [1:0] bub_cnt;
    logic [1:0] nxt_bub;
    logic       lu_hit;
    logic       inc_stall;
    logic       inc_flush;

    hazard_cmp u_cmp (
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .ex_ld     (ex_ld),
        .ex_rd     (ex_rd),
        .hit       (lu_hit)
    );

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halted      = 1'b0;
        nxt_state   = state;
        nxt_bub     = bub_cnt;
        inc_flush   = 1'b0;

        if (!rst_n) begin
            // Hold every register cleared while in reset.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (state == HALT) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            halted   = 1'b1;
            if (resume) begin
                nxt_state = RUN;
            end
        end else if (mem_busy) begin
            // Full freeze: nothing advances, state and bubbles held.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (state == LDSTALL) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            nxt_bub    = bub_cnt - 2'd1;
            if (bub_cnt == 2'd1) begin
                nxt_state = RUN;
            end
        end else if (ex_halt) begin
            // Let the syscall and older instructions drain; kill younger ones.
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            nxt_state  = HALT;
        end else if (ex_branch_taken) begin
            // ID instruction is wrong-path, so its load-use hit is irrelevant.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            inc_flush  = 1'b1;
        end else if (lu_hit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            if (LU_BUBBLES > 1) begin
                nxt_bub   = BUB_INIT;
                nxt_state = LDSTALL;
            end
        end
    end

    assign inc_stall = !pc_en && (state != HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            bub_cnt   <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= nxt_state;
            bub_cnt <= nxt_bub;
            if (inc_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (inc_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // A bubble occupies EX during LDSTALL, so no control transfer can resolve.
    a_no_ctrl_in_ldstall : assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == LDSTALL) |-> !(ex_branch_taken || ex_halt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam logic [8:0] O_RUN  = 9'b11111_000_0;
    localparam logic [8:0] O_LU   = 9'b00111_010_0;
    localparam logic [8:0] O_BR   = 9'b11111_110_0;
    localparam logic [8:0] O_HE   = 9'b01111_110_0;
    localparam logic [8:0] O_BUSY = 9'b00000_000_0;
    localparam logic [8:0] O_HALT = 9'b00000_000_1;
    localparam logic [8:0] O_RST  = 9'b00000_111_0;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, ex_ld, ex_branch_taken, ex_halt, mem_busy, resume;

    logic [8:0]  ov [3];
    logic [31:0] sc [3];
    logic [31:0] fc [3];

    logic        pc_a, ifid_a, idex_a, exmem_a, memwb_a, fifid_a, fidex_a, fexmem_a, hlt_a;
    logic        pc_b, ifid_b, idex_b, exmem_b, memwb_b, fifid_b, fidex_b, fexmem_b, hlt_b;
    logic        pc_c, ifid_c, idex_c, exmem_c, memwb_c, fifid_c, fidex_c, fexmem_c, hlt_c;
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
    logic [3:0]  sc_c, fc_c;

    typedef struct {
        logic [8:0]  o;
        logic [31:0] s;
        logic [31:0] f;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_err = 0;
    int stp   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(32)) u_a (
        .clk(clk), .rst_n(rst_a), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_ld(ex_ld), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt), .mem_busy(mem_busy),
        .resume(resume), .pc_en(pc_a), .ifid_en(ifid_a), .idex_en(idex_a),
        .exmem_en(exmem_a), .memwb_en(memwb_a), .ifid_flush(fifid_a),
        .idex_flush(fidex_a), .exmem_flush(fexmem_a), .halted(hlt_a),
        .stall_cnt(sc_a), .flush_cnt(fc_a)
    );

    hazard_ctrl #(.LU_BUBBLES(2), .CNT_W(32)) u_b (
        .clk(clk), .rst_n(rst_b), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_ld(ex_ld), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt), .mem_busy(mem_busy),
        .resume(resume), .pc_en(pc_b), .ifid_en(ifid_b), .idex_en(idex_b),
        .exmem_en(exmem_b), .memwb_en(memwb_b), .ifid_flush(fifid_b),
        .idex_flush(fidex_b), .exmem_flush(fexmem_b), .halted(hlt_b),
        .stall_cnt(sc_b), .flush_cnt(fc_b)
    );

    hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_c), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_ld(ex_ld), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt), .mem_busy(mem_busy),
        .resume(resume), .pc_en(pc_c), .ifid_en(ifid_c), .idex_en(idex_c),
        .exmem_en(exmem_c), .memwb_en(memwb_c), .ifid_flush(fifid_c),
        .idex_flush(fidex_c), .exmem_flush(fexmem_c), .halted(hlt_c),
        .stall_cnt(sc_c), .flush_cnt(fc_c)
    );

    assign ov[0] = {pc_a, ifid_a, idex_a, exmem_a, memwb_a, fifid_a, fidex_a, fexmem_a, hlt_a};
    assign ov[1] = {pc_b, ifid_b, idex_b, exmem_b, memwb_b, fifid_b, fidex_b, fexmem_b, hlt_b};
    assign ov[2] = {pc_c, ifid_c, idex_c, exmem_c, memwb_c, fifid_c, fidex_c, fexmem_c, hlt_c};
    assign sc[0] = sc_a;
    assign sc[1] = sc_b;
    assign sc[2] = {28'd0, sc_c};
    assign fc[0] = fc_a;
    assign fc[1] = fc_b;
    assign fc[2] = {28'd0, fc_c};

    task automatic set_in(input logic ld, input logic [4:0] rd, input logic [4:0] rs,
                          input logic [4:0] rt, input logic urs, input logic urt,
                          input logic br, input logic hlt, input logic busy, input logic res);
        ex_ld = ld; ex_rd = rd; id_rs = rs; id_rt = rt;
        id_use_rs = urs; id_use_rt = urt;
        ex_branch_taken = br; ex_halt = hlt; mem_busy = busy; resume = res;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_now(input int d, input logic [8:0] eo, input int es, input int ef);
        n_cmp++;
        assert (ov[d] === eo) else begin
            n_err++;
            $error("FAIL outs dut%0d step%0d got %b want %b", d, stp, ov[d], eo);
        end
        n_cmp++;
        assert (sc[d] === 32'(es)) else begin
            n_err++;
            $error("FAIL stall_cnt dut%0d step%0d got %0d want %0d", d, stp, sc[d], es);
        end
        n_cmp++;
        assert (fc[d] === 32'(ef)) else begin
            n_err++;
            $error("FAIL flush_cnt dut%0d step%0d got %0d want %0d", d, stp, fc[d], ef);
        end
    endtask

    // Inputs are already driven; expectation queued, checked mid-cycle, then one clock.
    task automatic step(input int d, input logic [8:0] eo, input int es, input int ef);
        exp_t e;
        e.o = eo; e.s = 32'(es); e.f = 32'(ef);
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        check_now(d, e.o, int'(e.s), int'(e.f));
        stp++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        idle();
        #1;
        check_now(0, O_RST, 0, 0);
        check_now(2, O_RST, 0, 0);
        @(posedge clk); #1;

        // LU_BUBBLES = 1
        rst_a = 1'b1;
        idle();                                                          step(0, O_RUN, 0, 0);
        set_in(1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 0, 0, 0);                   step(0, O_LU,  0, 0);
        idle();                                                          step(0, O_RUN, 1, 0);
        set_in(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0);                   step(0, O_RUN, 1, 0);
        set_in(1, 5'd5, 5'd3, 5'd5, 1, 1, 0, 0, 0, 0);                   step(0, O_LU,  1, 0);
        set_in(1, 5'd5, 5'd3, 5'd5, 1, 0, 0, 0, 0, 0);                   step(0, O_RUN, 2, 0);
        set_in(1, 5'd8, 5'd8, 5'd0, 1, 0, 1, 0, 0, 0);                   step(0, O_BR,  2, 0);
        idle();                                                          step(0, O_RUN, 2, 1);
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0);                   step(0, O_BUSY, 2, 1);
        idle();                                                          step(0, O_RUN, 3, 1);
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);                   step(0, O_HE,  3, 1);
        idle();                                                          step(0, O_HALT, 4, 1);
        for (int i = 0; i < 10; i++) begin
            idle();
            mem_busy = (i == 4);
            step(0, O_HALT, 4, 1);
        end
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);                   step(0, O_HALT, 4, 1);
        idle();                                                          step(0, O_RUN, 4, 1);
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);                   step(0, O_RUN, 4, 1);
        idle();                                                          step(0, O_RUN, 4, 1);
        rst_a = 1'b0;

        // LU_BUBBLES = 2
        rst_b = 1'b1;
        idle();                                                          step(1, O_RUN, 0, 0);
        set_in(1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 0, 0, 0);                   step(1, O_LU,  0, 0);
        idle();                                                          step(1, O_LU,  1, 0);
        idle();                                                          step(1, O_RUN, 2, 0);
        set_in(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0);                   step(1, O_RUN, 2, 0);
        set_in(1, 5'd8, 5'd8, 5'd0, 1, 0, 0, 0, 0, 0);                   step(1, O_LU,  2, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            mem_busy = 1'b1;
            step(1, O_BUSY, 3 + i, 0);
        end
        idle();                                                          step(1, O_LU,  6, 0);
        idle();                                                          step(1, O_RUN, 7, 0);
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);                   step(1, O_BUSY, 7, 0);
        idle();                                                          step(1, O_RUN, 8, 0);
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);                   step(1, O_BR,  8, 0);
        idle();                                                          step(1, O_RUN, 8, 1);
        rst_b = 1'b0;

        // CNT_W = 4: saturation and async reset out of HALT
        rst_c = 1'b1;
        idle();                                                          step(2, O_RUN, 0, 0);
        for (int i = 0; i < 20; i++) begin
            idle();
            mem_busy = 1'b1;
            step(2, O_BUSY, (i > 15) ? 15 : i, 0);
        end
        idle();                                                          step(2, O_RUN, 15, 0);
        for (int i = 0; i < 16; i++) begin
            idle();
            ex_branch_taken = 1'b1;
            step(2, O_BR, 15, i);
        end
        idle();                                                          step(2, O_RUN, 15, 15);
        set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);                   step(2, O_HE,  15, 15);
        idle();                                                          step(2, O_HALT, 15, 15);
        idle();
        #2;
        rst_c = 1'b0;
        #1;
        check_now(2, O_RST, 0, 0);
        @(posedge clk); #1;
        rst_c = 1'b1;
        idle();                                                          step(2, O_RUN, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
